// File: rtl/vfr_pkg.sv
// Shared definitions for the frame-reader packet reader: register map, bit
// positions, FSM encoding and packet type codes.
package vfr_pkg;

    localparam logic [2:0] REG_GO        = 3'd0;
    localparam logic [2:0] REG_STATUS    = 3'd1;
    localparam logic [2:0] REG_INTERRUPT = 3'd2;
    localparam logic [2:0] REG_ADDRESS   = 3'd3;
    localparam logic [2:0] REG_TYPE      = 3'd4;
    localparam logic [2:0] REG_SAMPLES   = 3'd5;
    localparam logic [2:0] REG_WORDS     = 3'd6;

    localparam int unsigned GO_BIT         = 0;
    localparam int unsigned IRQ_EN_BIT     = 1;
    localparam int unsigned RUNNING_BIT    = 0;
    localparam int unsigned IRQ_EOP_BIT    = 1;

    localparam logic [3:0] PKT_TYPE_VIDEO = 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } vfr_state_e;

endpackage

// File: rtl/vfr_packet_reader_fifo.sv
// Show-ahead read-data FIFO: head word is visible whenever the FIFO is non-empty.
module vfr_packet_reader_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         push,
    input  logic [DATA_WIDTH-1:0]        push_data,
    input  logic                         pop,
    output logic [DATA_WIDTH-1:0]        head,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [PTR_W:0]        count_q;
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == DEPTH_CNT);
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is allowed when a pop frees the slot in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
                2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/vfr_packet_reader.sv
// Packet reader: register slave, pipelined Avalon-MM read master and an
// Avalon-ST source emitting a type header beat followed by the fetched words.
module vfr_packet_reader
    import vfr_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned FIFO_DEPTH      = 8,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [2:0]            slave_address,
    input  logic                  slave_write,
    input  logic [31:0]           slave_writedata,
    input  logic                  slave_read,
    output logic [31:0]           slave_readdata,
    output logic                  slave_irq,
    output logic [ADDR_WIDTH-1:0] master_address,
    output logic                  master_read,
    input  logic                  master_waitrequest,
    input  logic [DATA_WIDTH-1:0] master_readdata,
    input  logic                  master_readdatavalid,
    output logic [DATA_WIDTH-1:0] dout_data,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  dout_startofpacket,
    output logic                  dout_endofpacket
);

    localparam int unsigned CNT_W          = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned BYTES_PER_WORD = DATA_WIDTH / 8;

    vfr_state_e state_q, state_d;

    logic        go_q, irq_en_q, running_q, irq_stat_q;
    logic [31:0] address_q, samples_q, words_q;
    logic [3:0]  type_q;

    logic [ADDR_WIDTH-1:0] mst_addr_q;
    logic [3:0]            work_type_q;
    logic [31:0]           work_words_q, issued_q, outstanding_q, beat_q;

    logic [DATA_WIDTH-1:0] fifo_head;
    logic [CNT_W-1:0]      fifo_count;
    logic                  fifo_full, fifo_empty, fifo_push;
    logic                  go_accept, wr_go, wr_irq, req_acc, beat_xfer, in_xfer;
    logic [31:0]           credit, rd_mux;

    assign wr_go     = slave_write && (slave_address == REG_GO);
    assign wr_irq    = slave_write && (slave_address == REG_INTERRUPT);
    assign go_accept = (state_q == ST_IDLE) && go_q;
    assign in_xfer   = (state_q == ST_HEADER) || (state_q == ST_STREAM);
    assign credit    = 32'(fifo_count) + outstanding_q;

    // Credit-based issue: words in flight plus words buffered never exceed FIFO capacity.
    assign master_read    = in_xfer && (issued_q < work_words_q)
                          && (outstanding_q < 32'(MAX_OUTSTANDING))
                          && (credit < 32'(FIFO_DEPTH)) && !fifo_full;
    assign master_address = mst_addr_q;
    assign req_acc        = master_read && !master_waitrequest;
    assign fifo_push      = master_readdatavalid && (outstanding_q != '0);
    assign beat_xfer      = (state_q == ST_STREAM) && dout_valid && dout_ready;
    assign slave_irq      = irq_stat_q && irq_en_q;

    vfr_packet_reader_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (master_readdata),
        .pop       (beat_xfer),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Control/status registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            go_q       <= 1'b0;
            irq_en_q   <= 1'b0;
            running_q  <= 1'b0;
            irq_stat_q <= 1'b0;
            address_q  <= '0;
            type_q     <= PKT_TYPE_VIDEO;
            samples_q  <= '0;
            words_q    <= '0;
        end else begin
            if (wr_go) begin
                irq_en_q <= slave_writedata[IRQ_EN_BIT];
                if (state_q == ST_IDLE && !go_q) go_q <= slave_writedata[GO_BIT];
            end
            if (state_q == ST_DONE) go_q <= 1'b0;

            if (go_accept)                 running_q <= 1'b1;
            else if (state_q == ST_DONE)   running_q <= 1'b0;

            // Completion wins over a simultaneous host clear.
            if (state_q == ST_DONE)                               irq_stat_q <= 1'b1;
            else if (wr_irq && slave_writedata[IRQ_EOP_BIT])      irq_stat_q <= 1'b0;

            if (slave_write) begin
                case (slave_address)
                    REG_ADDRESS: address_q <= slave_writedata;
                    REG_TYPE:    type_q    <= slave_writedata[3:0];
                    REG_SAMPLES: samples_q <= slave_writedata;
                    REG_WORDS:   words_q   <= slave_writedata;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (slave_address)
            REG_GO: begin
                rd_mux[GO_BIT]     = go_q;
                rd_mux[IRQ_EN_BIT] = irq_en_q;
            end
            REG_STATUS:    rd_mux[RUNNING_BIT] = running_q;
            REG_INTERRUPT: rd_mux[IRQ_EOP_BIT] = irq_stat_q;
            REG_ADDRESS:   rd_mux = address_q;
            REG_TYPE:      rd_mux = 32'(type_q);
            REG_SAMPLES:   rd_mux = samples_q;
            REG_WORDS:     rd_mux = words_q;
            default:       rd_mux = '0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)           slave_readdata <= '0;
        else if (slave_read) slave_readdata <= rd_mux;
    end

    // Working copy of the packet descriptor plus read-master and beat counters
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mst_addr_q   <= '0;
            work_type_q  <= '0;
            work_words_q <= '0;
            issued_q     <= '0;
            beat_q       <= '0;
        end else if (go_accept) begin
            mst_addr_q   <= ADDR_WIDTH'(address_q);
            work_type_q  <= type_q;
            work_words_q <= words_q;
            issued_q     <= '0;
            beat_q       <= '0;
        end else begin
            if (req_acc) begin
                mst_addr_q <= mst_addr_q + ADDR_WIDTH'(BYTES_PER_WORD);
                issued_q   <= issued_q + 32'd1;
            end
            if (beat_xfer) beat_q <= beat_q + 32'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            outstanding_q <= '0;
        end else begin
            case ({req_acc, fifo_push})
                2'b10:   outstanding_q <= outstanding_q + 32'd1;
                2'b01:   outstanding_q <= outstanding_q - 32'd1;
                default: outstanding_q <= outstanding_q;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d            = state_q;
        dout_valid         = 1'b0;
        dout_data          = '0;
        dout_startofpacket = 1'b0;
        dout_endofpacket   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (go_accept) state_d = ST_HEADER;
            end
            ST_HEADER: begin
                dout_valid         = 1'b1;
                dout_data          = DATA_WIDTH'(work_type_q);
                dout_startofpacket = 1'b1;
                dout_endofpacket   = (work_words_q == '0);
                if (dout_ready) state_d = (work_words_q == '0) ? ST_DONE : ST_STREAM;
            end
            ST_STREAM: begin
                dout_valid       = !fifo_empty;
                dout_data        = fifo_head;
                dout_endofpacket = !fifo_empty && (beat_q == work_words_q - 32'd1);
                if (dout_valid && dout_ready && dout_endofpacket) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_vfr_packet_reader.sv
// Scoreboard bench for vfr_packet_reader: stimulus queues expected beats,
// a monitor checks the stream and a memory responder checks read addresses.
module tb_vfr_packet_reader;
    import vfr_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;
    localparam int unsigned FD = 8;
    localparam int unsigned MO = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic [2:0]    slave_address;
    logic          slave_write;
    logic [31:0]   slave_writedata;
    logic          slave_read;
    logic [31:0]   slave_readdata;
    logic          slave_irq;
    logic [AW-1:0] master_address;
    logic          master_read;
    logic          master_waitrequest = 1'b0;
    logic [DW-1:0] master_readdata = '0;
    logic          master_readdatavalid = 1'b0;
    logic [DW-1:0] dout_data;
    logic          dout_valid;
    logic          dout_ready;
    logic          dout_startofpacket;
    logic          dout_endofpacket;

    vfr_packet_reader #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(FD), .MAX_OUTSTANDING(MO)
    ) dut (
        .clock(clock), .reset(reset),
        .slave_address(slave_address), .slave_write(slave_write),
        .slave_writedata(slave_writedata), .slave_read(slave_read),
        .slave_readdata(slave_readdata), .slave_irq(slave_irq),
        .master_address(master_address), .master_read(master_read),
        .master_waitrequest(master_waitrequest), .master_readdata(master_readdata),
        .master_readdatavalid(master_readdatavalid),
        .dout_data(dout_data), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .dout_startofpacket(dout_startofpacket), .dout_endofpacket(dout_endofpacket)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    typedef struct packed {
        logic [31:0] data;
        logic        sop;
        logic        eop;
    } beat_t;

    beat_t       sb[$];
    int          pkt_gen = 0;
    logic [31:0] pkt_base = '0;
    int          lat = 3;
    int          gap = 0;
    int          stall_idx = -1;
    int          stall_len = 0;
    int          cyc = 0;

    always @(posedge clock) cyc++;

    // Stream monitor
    int    mon_gen = 0;
    int    beats_seen = 0;
    beat_t exp_beat;
    always @(negedge clock) begin
        if (mon_gen != pkt_gen) begin
            mon_gen = pkt_gen;
            beats_seen = 0;
        end
        if (!reset && dout_valid && dout_ready) begin
            beats_seen++;
            if (sb.size() == 0) begin
                chk("unexpected_beat", 64'(sb.size()), 64'd1);
            end else begin
                exp_beat = sb.pop_front();
                chk("beat", 64'({dout_data, dout_startofpacket, dout_endofpacket}), 64'(exp_beat));
            end
        end
    end

    // Memory responder: fixed latency, optional alternate-cycle gaps and one stalled request
    logic [31:0] pq_addr[$];
    int          pq_due[$];
    int          seen_gen = 0;
    int          req_in_pkt = 0;
    int          stall_left = 0;
    bit          stalling = 1'b0;
    logic [31:0] stall_addr = '0;
    always @(negedge clock) begin
        if (seen_gen != pkt_gen) begin
            seen_gen   = pkt_gen;
            req_in_pkt = 0;
            stall_left = stall_len;
            stalling   = 1'b0;
        end
        master_readdatavalid = 1'b0;
        if (!reset && pq_due.size() != 0 && pq_due[0] <= cyc && (gap == 0 || cyc % 2 == 0)) begin
            master_readdatavalid = 1'b1;
            master_readdata      = mem_word(pq_addr.pop_front());
            void'(pq_due.pop_front());
        end
        if (stalling) begin
            chk("stall_read_held", 64'(master_read), 64'd1);
            chk("stall_addr_held", 64'(master_address), 64'(stall_addr));
        end
        if (master_read && req_in_pkt == stall_idx && stall_left > 0) begin
            if (!stalling) stall_addr = master_address;
            stalling           = 1'b1;
            stall_left--;
            master_waitrequest = 1'b1;
        end else begin
            stalling           = 1'b0;
            master_waitrequest = 1'b0;
            if (master_read) begin
                chk("read_addr", 64'(master_address), 64'(pkt_base + 32'(req_in_pkt * 4)));
                pq_addr.push_back(master_address);
                pq_due.push_back(cyc + lat);
                req_in_pkt++;
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        slave_address   = a;
        slave_writedata = d;
        slave_write     = 1'b1;
        @(posedge clock);
        #1;
        slave_write = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [2:0] a, input logic [31:0] e);
        slave_address = a;
        slave_read    = 1'b1;
        @(posedge clock);
        #1;
        slave_read = 1'b0;
        chk(name, 64'(slave_readdata), 64'(e));
    endtask

    task automatic expect_pkt(input logic [31:0] base, input logic [3:0] typ, input int words);
        pkt_gen++;
        pkt_base = base;
        sb.push_back('{data: 32'(typ), sop: 1'b1, eop: (words == 0)});
        for (int i = 0; i < words; i++)
            sb.push_back('{data: mem_word(base + 32'(i * 4)), sop: 1'b0, eop: (i == words - 1)});
    endtask

    task automatic start_pkt(input logic [31:0] base, input logic [3:0] typ, input int words,
                             input logic [31:0] go);
        expect_pkt(base, typ, words);
        wr(REG_ADDRESS, base);
        wr(REG_TYPE, 32'(typ));
        wr(REG_SAMPLES, 32'(words * 2));
        wr(REG_WORDS, 32'(words));
        wr(REG_GO, go);
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while (sb.size() != 0 && t < 400) begin
            wait_cycles(1);
            t++;
        end
        chk(name, 64'(sb.size()), 64'd0);
        wait_cycles(3);
    endtask

    task automatic chk_outputs_zero(input string name);
        chk(name, 64'({dout_valid, dout_startofpacket, dout_endofpacket, master_read, slave_irq}), 64'd0);
        chk({name, "_data"}, 64'({dout_data, master_address}), 64'd0);
        chk({name, "_readdata"}, 64'(slave_readdata), 64'd0);
    endtask

    initial begin
        int t;
        reset           = 1'b1;
        slave_address   = '0;
        slave_write     = 1'b0;
        slave_writedata = '0;
        slave_read      = 1'b0;
        dout_ready      = 1'b1;
        wait_cycles(2);
        chk_outputs_zero("reset_outputs");
        reset = 1'b0;
        wait_cycles(1);
        rd_chk("reset_status", REG_STATUS, 32'd0);

        // 1: three-word packet, irq enabled, go-to-header latency
        start_pkt(32'h1000, 4'd0, 3, 32'd3);
        chk("t1_not_yet_valid", 64'(dout_valid), 64'd0);
        wait_cycles(1);
        chk("t1_header_valid", 64'({dout_valid, dout_startofpacket, master_read}), 64'b111);
        chk("t1_first_addr", 64'(master_address), 64'h1000);
        rd_chk("t1_running", REG_STATUS, 32'd1);
        drain("t1_drain");
        rd_chk("t1_idle", REG_STATUS, 32'd0);
        chk("t1_irq_set", 64'(slave_irq), 64'd1);
        rd_chk("t1_int_status", REG_INTERRUPT, 32'd2);
        rd_chk("t1_go_cleared", REG_GO, 32'd2);
        wr(REG_INTERRUPT, 32'd2);
        chk("t1_irq_cleared", 64'(slave_irq), 64'd0);
        rd_chk("t1_int_cleared", REG_INTERRUPT, 32'd0);

        // 2: empty packet, header only, irq disabled
        start_pkt(32'h1100, 4'd5, 0, 32'd1);
        drain("t2_drain");
        chk("t2_no_reads", 64'(req_in_pkt), 64'd0);
        rd_chk("t2_int_status", REG_INTERRUPT, 32'd2);
        chk("t2_irq_masked", 64'(slave_irq), 64'd0);
        wr(REG_INTERRUPT, 32'd2);

        // 3: back-pressure caps fetch at FIFO depth
        dout_ready = 1'b0;
        start_pkt(32'h2000, 4'd3, 20, 32'd1);
        wait_cycles(50);
        chk("t3_fetch_capped", 64'(req_in_pkt), 64'(FD));
        chk("t3_header_held", 64'({dout_valid, dout_startofpacket}), 64'b11);
        dout_ready = 1'b1;
        drain("t3_drain");

        // 4: waitrequest stall on second read plus gapped read data
        stall_idx = 1;
        stall_len = 3;
        gap       = 1;
        start_pkt(32'h3000, 4'd1, 6, 32'd1);
        drain("t4_drain");
        stall_idx = -1;
        stall_len = 0;
        gap       = 0;

        // 5: mid-packet WORDS write and go are deferred to the next packet
        start_pkt(32'h4000, 4'd2, 4, 32'd1);
        wait_cycles(3);
        wr(REG_WORDS, 32'd5);
        wr(REG_GO, 32'd1);
        drain("t5_drain_first");
        rd_chk("t5_words_reg", REG_WORDS, 32'd5);
        expect_pkt(32'h4000, 4'd2, 5);
        wr(REG_GO, 32'd1);
        drain("t5_drain_second");

        // 6: reset mid-stream with reads outstanding
        lat = 6;
        start_pkt(32'h5000, 4'd7, 10, 32'd1);
        t = 0;
        while (!(pq_due.size() >= 2 && beats_seen >= 2) && t < 200) begin
            wait_cycles(1);
            t++;
        end
        chk("t6_mid_stream_reached", 64'(t < 200), 64'd1);
        reset = 1'b1;
        sb.delete();
        #1;
        chk_outputs_zero("t6_reset_outputs");
        wait_cycles(1);
        reset = 1'b0;
        t = 0;
        while (pq_due.size() != 0 && t < 50) begin
            wait_cycles(1);
            t++;
        end
        wait_cycles(3);
        chk("t6_idle_after_late_data", 64'(dout_valid), 64'd0);
        rd_chk("t6_address_reset", REG_ADDRESS, 32'd0);
        rd_chk("t6_status_reset", REG_STATUS, 32'd0);
        lat = 3;
        start_pkt(32'h6000, 4'd4, 3, 32'd1);
        drain("t6_drain_after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule

// File: doc/vfr_packet_reader.md
Name: vfr_packet_reader

Overview:
Packet reader (PRC) driven by the frame-reader controller's Avalon-MM master.
- Register slave accepts packet address, type, sample count and word count, then a go command.
- Once started, fetches the packet words from memory through a pipelined Avalon-MM read master and emits them as an Avalon-ST packet: one header beat carrying the packet type, then the words.
- Raises an end-of-packet interrupt that the controller clears through the slave.

Parameters:
DATA_WIDTH, 32, memory word and stream data width (bits)
ADDR_WIDTH, 32, read-master byte address width
FIFO_DEPTH, 8, read-data FIFO entries; power of 2, >= 2
MAX_OUTSTANDING, 4, maximum in-flight read transactions

Ports:
clock  in  1  single clock
reset  in  1  asynchronous, active-high reset
slave_address  in  3  register index 0..6
slave_write  in  1  register write strobe
slave_writedata  in  32  write data
slave_read  in  1  register read strobe
slave_readdata  out  32  read data, valid 1 cycle after slave_read
slave_irq  out  1  level interrupt = |(irq_status & irq_enable)
master_address  out  ADDR_WIDTH  byte address of current read
master_read  out  1  read request
master_waitrequest  in  1  stall; request held while high
master_readdata  in  DATA_WIDTH  returned word
master_readdatavalid  in  1  returned word valid
dout_data  out  DATA_WIDTH  stream data
dout_valid  out  1  stream valid
dout_ready  in  1  stream ready; beat transfers when valid & ready
dout_startofpacket  out  1  first beat (header)
dout_endofpacket  out  1  last beat

Behaviour:
Register map (word index):
- 0 GO: bit0 go (self-clears at DONE), bit1 irq_enable.
- 1 STATUS (RO): bit0 running.
- 2 INTERRUPT: bit1 end-of-packet status; writing 1 to bit1 clears it.
- 3 ADDRESS
- 4 TYPE: low 4 bits used.
- 5 SAMPLES: stored and readable only; no effect on transfer.
- 6 WORDS: word count.
- Regs 3-6 writable at any time. Values are copied to working regs when go is accepted, so writes mid-packet affect only the next packet.
- Write to GO with bit0=1 while running: bit1 updates; bit0 is ignored.
- Reads of undefined addresses return 0.

Reset values:
- All outputs 0.
- All registers 0.
- FSM in IDLE; FIFO empty; counters 0.

FSM:
- IDLE -> HEADER on an accepted go; running=1 from the next cycle.
- HEADER: dout_valid=1, dout_data = zero-extended type, dout_startofpacket=1, dout_endofpacket=(words==0). On transfer -> DONE if words==0, else STREAM.
- STREAM: read master and FIFO run concurrently.
  - FIFO head drives dout_data; dout_valid = !fifo_empty.
  - dout_endofpacket=1 on beat number `words`.
  - On transfer of that beat -> DONE.
- DONE (1 cycle):
  - Clear running and go bit0.
  - Set irq status bit1 unconditionally; slave_irq asserts only if irq_enable.
  - -> IDLE.

Read master:
- Issue condition: state in HEADER/STREAM, issued < words, outstanding < MAX_OUTSTANDING, and fifo_count + outstanding < FIFO_DEPTH.
- A request is accepted when master_read & !master_waitrequest. On acceptance: address += DATA_WIDTH/8, issued++, outstanding++.
- While waitrequest is high, address and read are held stable.
- Each readdatavalid pushes into the FIFO and decrements outstanding. The credit rule guarantees no overflow.
- Address arithmetic wraps modulo 2^ADDR_WIDTH. Counters are 32-bit.

Boundary conditions:
- Same-cycle DONE set and host clear of irq bit1: set wins.
- FIFO push and pop in the same cycle while full: both take effect.
- dout_ready held low: FIFO fills, issue stops; no data lost.
- Reset mid-packet: returns to reset state immediately. Readdatavalid arriving after reset is ignored because outstanding=0 drops the pushes.

Latency:
- Go write to header valid: 2 cycles.
- First master_read asserts in the same cycle as header valid.

Decomposition:
- Shared package vfr_pkg holds:
  - Register index constants (GO=0, STATUS=1, INTERRUPT=2, ADDRESS=3, TYPE=4, SAMPLES=5, WORDS=6), shared with the controller.
  - GO/INTERRUPT bit positions.
  - FSM state encoding.
  - Packet type constant VIDEO=0.
- One sub-module, vfr_packet_reader_fifo: synchronous show-ahead FIFO with DATA_WIDTH x FIFO_DEPTH, count, and full/empty flags.

Test Plan:
1. Write ADDRESS=0x1000, TYPE=0, WORDS=3, GO=3; memory returns A,B,C; ready=1 -> stream beats 0x0(sop), A, B, C(eop). Reads go to 0x1000, 0x1004, 0x1008. STATUS.bit0 is 1 during the packet and 0 after. slave_irq=1. Write INTERRUPT=2 -> slave_irq=0.
2. WORDS=0, GO=1 -> single beat, data=TYPE, sop=eop=1. No master_read issued. irq bit1 set but slave_irq=0 (disabled).
3. WORDS=20, dout_ready=0 for 50 cycles -> at most FIFO_DEPTH words fetched, no FIFO overflow. After ready=1, all 20 words emitted in order.
4. waitrequest high for 3 cycles on the 2nd read -> master_address/master_read stable throughout. Data order preserved; 1-cycle gaps in readdatavalid tolerated.
5. During a packet, write WORDS=5 and GO=1 -> current packet length unchanged; second go ignored. The next go uses 5.
6. Assert reset mid-STREAM with 2 reads outstanding -> all outputs 0 immediately. Late readdatavalid not pushed. A new go works normally.
